// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_arb_pkg
// Description : Shared constants for the data-memory arbiter: memory op codes,
//               requester indices and the lock FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

    // Memory access size/extension codes, forwarded to the memory unchanged
    localparam logic [2:0] MEM_OP_LW  = 3'b000;
    localparam logic [2:0] MEM_OP_SW  = 3'b000;
    localparam logic [2:0] MEM_OP_SH  = 3'b001;
    localparam logic [2:0] MEM_OP_SB  = 3'b010;
    localparam logic [2:0] MEM_OP_LH  = 3'b100;
    localparam logic [2:0] MEM_OP_LHU = 3'b101;
    localparam logic [2:0] MEM_OP_LB  = 3'b110;
    localparam logic [2:0] MEM_OP_LBU = 3'b111;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/dm_arb_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dm_arb_wait_ctr
// Description : Saturating count of consecutive cycles M1 has been denied.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arb_wait_ctr #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX_WAIT)) begin
            r_count <= r_count + WAIT_W'(1);
        end
    end

    assign o_sat = (r_count == c_MAX_WAIT);

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Two-requester arbiter for the single-port data memory. M0 has
//               fixed priority; a starved M1 is forced through after MAX_WAIT
//               denied cycles. Define DM_ARB_LOCK_EN for the lock ports/FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m0_we_i,
    input  logic [2:0]  m0_mem_op_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic        m1_we_i,
    input  logic [2:0]  m1_mem_op_i,
`ifdef DM_ARB_LOCK_EN
    input  logic        m0_lock_i,
    input  logic        m1_lock_i,
`endif
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic        dm_we_o,
    output logic [2:0]  dm_mem_op_o,
    input  logic [31:0] dm_rdata_i
);

    logic [1:0]  w_req;
    logic [1:0]  w_we;
    logic [1:0]  w_base;
    logic [1:0]  w_gnt;
    logic        w_sat;
    logic        w_ctr_inc;
    logic        w_ctr_clr;
    logic [1:0]  r_rvalid;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    assign w_req[M0] = m0_req_i;
    assign w_req[M1] = m1_req_i;
    assign w_we[M0]  = m0_we_i;
    assign w_we[M1]  = m1_we_i;

    assign w_ctr_inc = w_req[M1] & ~w_gnt[M1];
    assign w_ctr_clr = ~w_req[M1] | w_gnt[M1];

    dm_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_ctr_inc),
        .i_clr (w_ctr_clr),
        .o_sat (w_sat)
    );

    // Unlocked winner: starved M1 first, then M0, then M1
    always_comb begin
        w_base = '0;
        if (w_req[M1] && w_sat) begin
            w_base[M1] = 1'b1;
        end else if (w_req[M0]) begin
            w_base[M0] = 1'b1;
        end else if (w_req[M1]) begin
            w_base[M1] = 1'b1;
        end
    end

`ifdef DM_ARB_LOCK_EN
    lock_state_t r_lock_state;
    lock_state_t w_lock_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_state <= IDLE;
        end else begin
            r_lock_state <= w_lock_next;
        end
    end

    // While owned, only the owner can be granted; the starvation override is ignored
    always_comb begin
        w_gnt       = '0;
        w_lock_next = r_lock_state;
        case (r_lock_state)
            OWN0:    w_gnt[M0] = w_req[M0];
            OWN1:    w_gnt[M1] = w_req[M1];
            default: w_gnt     = w_base;
        endcase
        if (!rst) begin
            w_gnt = '0;
        end
        case (r_lock_state)
            IDLE: begin
                if (w_gnt[M0] && m0_lock_i) begin
                    w_lock_next = OWN0;
                end else if (w_gnt[M1] && m1_lock_i) begin
                    w_lock_next = OWN1;
                end
            end
            OWN0: begin
                if (!m0_lock_i && (w_gnt[M0] || !w_req[M0])) begin
                    w_lock_next = IDLE;
                end
            end
            OWN1: begin
                if (!m1_lock_i && (w_gnt[M1] || !w_req[M1])) begin
                    w_lock_next = IDLE;
                end
            end
            default: w_lock_next = IDLE;
        endcase
    end
`else
    assign w_gnt = w_base & {2{rst}};
`endif

    assign m0_gnt_o = w_gnt[M0];
    assign m1_gnt_o = w_gnt[M1];

    always_comb begin
        dm_addr_o   = '0;
        dm_wdata_o  = '0;
        dm_we_o     = 1'b0;
        dm_mem_op_o = 3'b000;
        if (w_gnt[M0]) begin
            dm_addr_o   = m0_addr_i;
            dm_wdata_o  = m0_wdata_i;
            dm_we_o     = m0_we_i;
            dm_mem_op_o = m0_mem_op_i;
        end else if (w_gnt[M1]) begin
            dm_addr_o   = m1_addr_i;
            dm_wdata_o  = m1_wdata_i;
            dm_we_o     = m1_we_i;
            dm_mem_op_o = m1_mem_op_i;
        end
    end

    // Load data is captured at the grant edge; rdata holds until that port's next load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_rvalid <= w_gnt & ~w_we;
            if (w_gnt[M0] && !w_we[M0]) begin
                r_rdata0 <= dm_rdata_i;
            end
            if (w_gnt[M1] && !w_we[M1]) begin
                r_rdata1 <= dm_rdata_i;
            end
        end
    end

    assign m0_rvalid_o = r_rvalid[M0];
    assign m1_rvalid_o = r_rvalid[M1];
    assign m0_rdata_o  = r_rdata0;
    assign m1_rdata_o  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Directed and randomized checks of dm_arbiter against a
//               cycle-level behavioural model and a byte-array memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int MAX_WAIT = 8;
    localparam int WAIT_W   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [2:0]  m0_mem_op_i, m1_mem_op_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i;
    logic        dm_we_o;
    logic [2:0]  dm_mem_op_o;
`ifdef DM_ARB_LOCK_EN
    logic        m0_lock_i = 1'b0;
    logic        m1_lock_i = 1'b0;
`endif

    always #5 clk = ~clk;

    dm_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_we_i(m0_we_i), .m0_mem_op_i(m0_mem_op_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_we_i(m1_we_i), .m1_mem_op_i(m1_mem_op_i),
`ifdef DM_ARB_LOCK_EN
        .m0_lock_i(m0_lock_i), .m1_lock_i(m1_lock_i),
`endif
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_we_o(dm_we_o),
        .dm_mem_op_o(dm_mem_op_o), .dm_rdata_i(dm_rdata_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem  [0:1023];   // memory seen by the DUT, written from what the DUT drives
    logic [7:0] rmem [0:1023];   // reference memory, written from the model's predicted grants

    int          waited;
    bit          exp_g0, exp_g1, exp_rv0, exp_rv1, exp_we;
    logic [31:0] exp_rd0, exp_rd1, exp_addr, exp_wdata;
    logic [2:0]  exp_op;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_op;

    function automatic logic [31:0] fmt(input logic [2:0] op, input logic [7:0] b0, b1, b2, b3);
        case (op)
            MEM_OP_LH:  return {{16{b1[7]}}, b1, b0};
            MEM_OP_LHU: return {16'h0, b1, b0};
            MEM_OP_LB:  return {{24{b0[7]}}, b0};
            MEM_OP_LBU: return {24'h0, b0};
            default:    return {b3, b2, b1, b0};
        endcase
    endfunction

    assign dm_rdata_i = fmt(dm_mem_op_o, mem[dm_addr_o[9:0]], mem[dm_addr_o[9:0] + 10'd1],
                            mem[dm_addr_o[9:0] + 10'd2], mem[dm_addr_o[9:0] + 10'd3]);

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        return fmt(op, rmem[a[9:0]], rmem[a[9:0] + 10'd1], rmem[a[9:0] + 10'd2], rmem[a[9:0] + 10'd3]);
    endfunction

    task automatic store(input bit to_ref, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (op == MEM_OP_SB) ? 1 : (op == MEM_OP_SH) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            logic [9:0] ix;
            ix = a[9:0] + 10'(i);
            if (to_ref) rmem[ix] = d[8*i +: 8];
            else        mem[ix]  = d[8*i +: 8];
        end
    endtask

    function automatic void model_reset();
        waited  = 0;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
    endfunction

    // Winner from the arbitration rules; memory fields follow the winner
    function automatic void predict();
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (rst === 1'b1) begin
            if (m1_req_i && waited >= MAX_WAIT) exp_g1 = 1'b1;
            else if (m0_req_i)                  exp_g0 = 1'b1;
            else if (m1_req_i)                  exp_g1 = 1'b1;
        end
        {exp_we, exp_op, exp_addr, exp_wdata} = '0;
        if (exp_g0)      {exp_we, exp_op, exp_addr, exp_wdata} = {m0_we_i, m0_mem_op_i, m0_addr_i, m0_wdata_i};
        else if (exp_g1) {exp_we, exp_op, exp_addr, exp_wdata} = {m1_we_i, m1_mem_op_i, m1_addr_i, m1_wdata_i};
    endfunction

    task automatic settle();
        #2;
        predict();
        s_we = dm_we_o; s_op = dm_mem_op_o; s_addr = dm_addr_o; s_wdata = dm_wdata_o;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (s_we) store(1'b0, s_op, s_addr, s_wdata);
            exp_rv0 = exp_g0 && !m0_we_i;
            exp_rv1 = exp_g1 && !m1_we_i;
            if (exp_rv0) exp_rd0 = ref_load(m0_mem_op_i, m0_addr_i);
            if (exp_rv1) exp_rd1 = ref_load(m1_mem_op_i, m1_addr_i);
            if (exp_g0 && m0_we_i) store(1'b1, m0_mem_op_i, m0_addr_i, m0_wdata_i);
            if (exp_g1 && m1_we_i) store(1'b1, m1_mem_op_i, m1_addr_i, m1_wdata_i);
            if (m1_req_i && !exp_g1) waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
            else                     waited = 0;
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic drive0(input logic req, input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        m0_req_i = req; m0_we_i = we; m0_mem_op_i = op; m0_addr_i = a; m0_wdata_i = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        m1_req_i = req; m1_we_i = we; m1_mem_op_i = op; m1_addr_i = a; m1_wdata_i = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive0(1'b1, 1'b1, MEM_OP_SW, 32'h40, 32'h1111_1111);
        drive1(1'b1, 1'b1, MEM_OP_SW, 32'h80, 32'h2222_2222);
        model_reset();
        repeat (2) begin
            @(negedge clk); #2;
            n_checks++;
            if ({m0_gnt_o, m1_gnt_o, dm_we_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== 69'd0) begin
                n_fail++;
                $display("FAIL reset_state: got g=%b%b we=%b rv=%b%b rd0=%h rd1=%h, required all zero",
                         m0_gnt_o, m1_gnt_o, dm_we_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        drive0(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
    endtask

    task automatic test_m0_alone();
        drive0(1'b1, 1'b1, MEM_OP_SW, 32'h100, 32'hDEAD_BEEF);
        drive1(1'b0, 1'b1, MEM_OP_SB, 32'h3FC, 32'h5555_5555);
        settle();
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o, dm_mem_op_o, dm_addr_o, dm_wdata_o} !== {3'b101, 3'b000, 32'h100, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL m0_store: got g=%b%b we=%b op=%b a=%h d=%h, required g=10 we=1 op=000 a=100 d=deadbeef",
                     m0_gnt_o, m1_gnt_o, dm_we_o, dm_mem_op_o, dm_addr_o, dm_wdata_o);
        end
        tick();
        drive0(1'b1, 1'b0, MEM_OP_LW, 32'h100, 32'h0);
        settle();
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o, dm_addr_o, m0_rvalid_o} !== {3'b100, 32'h100, 1'b0}) begin
            n_fail++;
            $display("FAIL m0_load_grant: got g=%b%b we=%b a=%h rv0=%b, required g=10 we=0 a=100 rv0=0",
                     m0_gnt_o, m1_gnt_o, dm_we_o, dm_addr_o, m0_rvalid_o);
        end
        tick();
        drive0(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({m0_rvalid_o, m0_rdata_o, m1_rvalid_o, m1_rdata_o, m0_gnt_o, m1_gnt_o, dm_addr_o}
                !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL m0_load_return: got rv0=%b rd0=%h rv1=%b rd1=%h g=%b%b a=%h, required rv0=1 rd0=deadbeef m1 idle",
                     m0_rvalid_o, m0_rdata_o, m1_rvalid_o, m1_rdata_o, m0_gnt_o, m1_gnt_o, dm_addr_o);
        end
        tick();
        settle();
        n_checks++;
        if ({m0_rvalid_o, m0_rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL m0_rdata_hold: got rv0=%b rd0=%h, required rv0=0 rd0=deadbeef", m0_rvalid_o, m0_rdata_o);
        end
        tick();
    endtask

    task automatic test_starvation();
        drive0(1'b1, 1'b0, MEM_OP_LW, 32'h100, 32'h0);
        drive1(1'b1, 1'b0, MEM_OP_LW, 32'h200, 32'h0);
        for (int k = 0; k < 20; k++) begin
            logic [1:0] want;
            want = (k == 8 || k == 17) ? 2'b01 : 2'b10;
            settle();
            n_checks++;
            if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== {want, exp_rv0, exp_rv1}) begin
                n_fail++;
                $display("FAIL starvation cycle %0d: got g=%b%b rv=%b%b, required g=%b rv=%b%b",
                         k, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, want, exp_rv0, exp_rv1);
            end
            tick();
        end
        drive0(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        tick();
    endtask

    task automatic test_byte_store();
        drive1(1'b1, 1'b1, MEM_OP_SB, 32'h203, 32'hFFFF_FF5A);
        settle();
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o, dm_mem_op_o, dm_addr_o} !== {3'b011, 3'b010, 32'h203}) begin
            n_fail++;
            $display("FAIL m1_sb: got g=%b%b we=%b op=%b a=%h, required g=01 we=1 op=010 a=203",
                     m0_gnt_o, m1_gnt_o, dm_we_o, dm_mem_op_o, dm_addr_o);
        end
        tick();
        drive1(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        drive0(1'b1, 1'b0, MEM_OP_LBU, 32'h203, 32'h0);
        settle();
        tick();
        drive0(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'h0000_005A}) begin
            n_fail++;
            $display("FAIL m0_lbu: got rv0=%b rd0=%h, required rv0=1 rd0=0000005a", m0_rvalid_o, m0_rdata_o);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        drive0(1'b1, 1'b0, MEM_OP_LH, 32'h202, 32'h0);
        drive1(1'b1, 1'b1, MEM_OP_SW, 32'h300, 32'hCAFE_F00D);
        settle();
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o, dm_mem_op_o, dm_addr_o} !== {3'b100, 3'b100, 32'h202}) begin
            n_fail++;
            $display("FAIL simul_m0_first: got g=%b%b we=%b op=%b a=%h, required g=10 we=0 op=100 a=202",
                     m0_gnt_o, m1_gnt_o, dm_we_o, dm_mem_op_o, dm_addr_o);
        end
        tick();
        drive0(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o, dm_addr_o, dm_wdata_o, m0_rvalid_o, m0_rdata_o, m0_rdata_o[31:8]}
                !== {3'b011, 32'h300, 32'hCAFE_F00D, 1'b1, exp_rd0, 24'h00005A}) begin
            n_fail++;
            $display("FAIL simul_m1_second: got g=%b%b we=%b a=%h d=%h rv0=%b rd0=%h, required g=01 we=1 a=300 d=cafef00d rv0=1 rd0=%h",
                     m0_gnt_o, m1_gnt_o, dm_we_o, dm_addr_o, dm_wdata_o, m0_rvalid_o, m0_rdata_o, exp_rd0);
        end
        tick();
        drive1(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o, m1_rvalid_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL simul_idle: got g=%b%b we=%b rv1=%b, required all zero", m0_gnt_o, m1_gnt_o, dm_we_o, m1_rvalid_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive0(1'b1, 1'b0, MEM_OP_LW, 32'h100, 32'h0);
        drive1(1'b1, 1'b1, MEM_OP_SW, 32'h300, 32'h1234_5678);
        repeat (5) begin
            settle();
            tick();
        end
        settle();
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o, m0_rvalid_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_assert: got g=%b%b we=%b rv0=%b, required all zero", m0_gnt_o, m1_gnt_o, dm_we_o, m0_rvalid_o);
        end
        tick();
        settle();
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o, m0_rvalid_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got g=%b%b we=%b rv0=%b, required all zero", m0_gnt_o, m1_gnt_o, dm_we_o, m0_rvalid_o);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [1:0] want;
            want = (k == 8) ? 2'b01 : 2'b10;
            settle();
            n_checks++;
            if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o} !== {want, exp_rv0} || (k == 0 && m0_rvalid_o !== 1'b0)) begin
                n_fail++;
                $display("FAIL reset_mid_after cycle %0d: got g=%b%b rv0=%b, required g=%b rv0=%b",
                         k, m0_gnt_o, m1_gnt_o, m0_rvalid_o, want, exp_rv0);
            end
            tick();
        end
        drive0(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        tick();
    endtask

`ifdef DM_ARB_LOCK_EN
    task automatic test_lock();
        drive1(1'b1, 1'b0, MEM_OP_LW, 32'h100, 32'h0);
        m1_lock_i = 1'b1;
        settle();
        {exp_g0, exp_g1} = 2'b01;
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_take: got g=%b%b, required 01", m0_gnt_o, m1_gnt_o);
        end
        tick();
        drive0(1'b1, 1'b0, MEM_OP_LW, 32'h104, 32'h0);
        drive1(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        {exp_g0, exp_g1} = 2'b00;
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL lock_hold: got g=%b%b, required 00", m0_gnt_o, m1_gnt_o);
        end
        tick();
        drive1(1'b1, 1'b1, MEM_OP_SW, 32'h100, 32'h1234_5678);
        m1_lock_i = 1'b0;
        settle();
        {exp_g0, exp_g1} = 2'b01;
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, dm_we_o} !== 3'b011) begin
            n_fail++;
            $display("FAIL lock_release: got g=%b%b we=%b, required g=01 we=1", m0_gnt_o, m1_gnt_o, dm_we_o);
        end
        tick();
        drive1(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL lock_after: got g=%b%b, required 10", m0_gnt_o, m1_gnt_o);
        end
        tick();
        drive0(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        tick();
    endtask
`endif

    task automatic test_random();
        logic [2:0] st_ops [3];
        logic [2:0] ld_ops [5];
        bit         hold0, hold1;
        st_ops = '{MEM_OP_SW, MEM_OP_SH, MEM_OP_SB};
        ld_ops = '{MEM_OP_LW, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LB, MEM_OP_LBU};
        hold0 = 1'b0;
        hold1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic we;
            rst = ($urandom_range(0, 63) != 0);
            if (!hold0) begin
                we = 1'($urandom_range(0, 1));
                drive0($urandom_range(0, 3) != 0, we, we ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)],
                       32'($urandom_range(0, 1019)), $urandom);
            end
            if (!hold1) begin
                we = 1'($urandom_range(0, 1));
                drive1($urandom_range(0, 3) != 0, we, we ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)],
                       32'($urandom_range(0, 1019)), $urandom);
            end
            if (!rst) model_reset();
            settle();
            n_checks++;
            if ({m0_gnt_o, m1_gnt_o, dm_we_o, dm_mem_op_o, dm_addr_o, dm_wdata_o}
                    !== {exp_g0, exp_g1, exp_we, exp_op, exp_addr, exp_wdata}) begin
                n_fail++;
                $display("FAIL rand_bus cycle %0d: got g=%b%b we=%b op=%b a=%h d=%h, required g=%b%b we=%b op=%b a=%h d=%h",
                         c, m0_gnt_o, m1_gnt_o, dm_we_o, dm_mem_op_o, dm_addr_o, dm_wdata_o,
                         exp_g0, exp_g1, exp_we, exp_op, exp_addr, exp_wdata);
            end
            n_checks++;
            if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== {exp_rv0, exp_rv1, exp_rd0, exp_rd1}) begin
                n_fail++;
                $display("FAIL rand_return cycle %0d: got rv=%b%b rd0=%h rd1=%h, required rv=%b%b rd0=%h rd1=%h",
                         c, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
            end
            tick();
            hold0 = rst && m0_req_i && !exp_g0;
            hold1 = rst && m1_req_i && !exp_g1;
        end
        rst = 1'b1;
        drive0(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, MEM_OP_LW, 32'h0, 32'h0);
        settle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 8'($urandom);
            rmem[i] = mem[i];
        end
        model_reset();
        test_reset();
        test_m0_alone();
        test_starvation();
        test_byte_store();
        test_simultaneous();
        test_reset_mid();
`ifdef DM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
